// File: rtl/fetch_unit.sv
// Program counter, instruction register and memory data register for the CPU fetch stage.
// Also holds the halt latch and a saturating count of loaded instructions.
module fetch_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              resume,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [DATA_W-1:0] mdr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_ir_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_halted_nxt;
    logic [ADDR_W-1:0] w_operand;

    assign w_operand = r_ir[ADDR_W-1:0];

    // Strobe priority: ld_pc over ld_ir over inc_pc; nothing moves while halted.
    always_comb begin
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_cnt_nxt    = r_cnt;
        w_halted_nxt = r_halted;
        if (!r_halted) begin
            if (ld_pc) begin
                w_pc_nxt = w_operand;
            end else if (ld_ir) begin
                w_ir_nxt = r_mdr;
                w_pc_nxt = r_pc + ADDR_W'(1);
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else if (inc_pc) begin
                w_pc_nxt = r_pc + ADDR_W'(1);
            end
        end
        if (halt) begin
            w_halted_nxt = 1'b1;
        end else if (resume) begin
            w_halted_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_halted <= w_halted_nxt;
            r_cnt    <= w_cnt_nxt;
            // MDR is a passive capture and ignores the halt latch.
            if (rd) begin
                r_mdr <= mem_data;
            end
        end
    end

    assign addr        = sel ? r_pc : w_operand;
    assign opcode      = r_ir[DATA_W-1:DATA_W-3];
    assign operand     = w_operand;
    assign mdr         = r_mdr;
    assign pc          = r_pc;
    assign halted      = r_halted;
    assign instr_count = r_cnt;

endmodule
